// File: rtl/hv_wdg_reg_scan_pkg.sv
// Shared widths, CRC parameters, scan FSM state encoding and read-response payload
// for the watchdog register-integrity scanner and the regfile CRC path.
package hv_wdg_reg_scan_pkg;

    localparam int unsigned REG_AW    = 7;
    localparam int unsigned REG_DW    = 8;
    localparam int unsigned REG_CRC_W = 8;

    localparam logic [REG_CRC_W-1:0] CRC_POLY = 8'h07;
    localparam logic [REG_CRC_W-1:0] CRC_INIT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_REQ  = 3'd2,
        ST_CHK  = 3'd3,
        ST_NEXT = 3'd4
    } scan_state_e;

    // Read response returned by the arbiter alongside the ack
    typedef struct packed {
        logic [REG_DW-1:0]    data;
        logic [REG_CRC_W-1:0] crc;
    } rd_rsp_t;

endpackage

// File: rtl/hv_wdg_reg_scan_if.sv
// Watchdog-scan read port between the scanner (master) and the reg access arbiter (slave).
//   rd_req : read request, held until ack or timeout
//   addr   : register address, stable while rd_req is high
//   ack    : one-cycle read acknowledge
//   rsp    : register data and stored CRC, valid with ack
interface hv_wdg_reg_scan_if;
    import hv_wdg_reg_scan_pkg::*;

    logic              rd_req;
    logic [REG_AW-1:0] addr;
    logic              ack;
    rd_rsp_t           rsp;

    modport master (output rd_req, addr, input ack, rsp);
    modport slave  (input rd_req, addr, output ack, rsp);

endinterface

// File: rtl/hv_reg_crc_calc.sv
// Combinational CRC over {addr, data}, MSB first, no final XOR. Shared with the regfile
// write path so stored and recomputed CRCs always agree.
//   addr  : register address
//   data  : register data
//   crc_c : CRC result (combinational)
module hv_reg_crc_calc
    import hv_wdg_reg_scan_pkg::*;
#(
    parameter int unsigned          AW    = REG_AW,
    parameter int unsigned          DW    = REG_DW,
    parameter int unsigned          CRC_W = REG_CRC_W,
    parameter logic [CRC_W-1:0]     POLY  = CRC_POLY,
    parameter logic [CRC_W-1:0]     INIT  = CRC_INIT
) (
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    data,
    output logic [CRC_W-1:0] crc_c
);

    logic [AW+DW-1:0] msg;
    logic [CRC_W-1:0] crc;

    // Unrolled serial LFSR: one shift per message bit, feedback = crc MSB ^ message bit
    always_comb begin
        msg = {addr, data};
        crc = INIT;
        for (int i = AW + DW - 1; i >= 0; i--) begin
            crc = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ msg[i]) ? POLY : '0);
        end
    end

    assign crc_c = crc;

endmodule

// File: rtl/hv_wdg_reg_scan.sv
// Background register-integrity scanner. Periodically sweeps an address window with
// reads on the watchdog-scan arbiter port, recomputes each register's CRC and reports
// mismatches and ack timeouts.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_scan_en        : scanner enable (level)
//   rac              : read port to the arbiter (req/addr out, ack/data/crc in)
//   o_scan_busy      : sweep in progress (REQ/CHK/NEXT)
//   o_scan_done      : pulse, sweep finished
//   o_crc_err        : pulse, CRC mismatch
//   o_to_err         : pulse, ack timeout
//   o_err_addr       : address of most recent error
//   o_crc_err_cnt    : saturating CRC-mismatch count
//   o_to_err_cnt     : saturating timeout count
module hv_wdg_reg_scan
    import hv_wdg_reg_scan_pkg::*;
#(
    parameter int unsigned SCAN_START_ADDR = 0,
    parameter int unsigned SCAN_END_ADDR   = 63,
    parameter int unsigned SCAN_INTV_CYC   = 1000,
    parameter int unsigned ACK_TO_CYC      = 64,
    parameter int unsigned ERR_CNT_W       = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_scan_en,
    hv_wdg_reg_scan_if.master    rac,
    output logic                 o_scan_busy,
    output logic                 o_scan_done,
    output logic                 o_crc_err,
    output logic                 o_to_err,
    output logic [REG_AW-1:0]    o_err_addr,
    output logic [ERR_CNT_W-1:0] o_crc_err_cnt,
    output logic [ERR_CNT_W-1:0] o_to_err_cnt
);

    localparam int unsigned INTV_W = $clog2(SCAN_INTV_CYC + 1);
    localparam int unsigned TO_W   = $clog2(ACK_TO_CYC + 1);

    localparam logic [REG_AW-1:0] START_A   = REG_AW'(SCAN_START_ADDR);
    localparam logic [REG_AW-1:0] END_A     = REG_AW'(SCAN_END_ADDR);
    localparam logic [INTV_W-1:0] INTV_LAST = INTV_W'(SCAN_INTV_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TO_CYC - 1);

    scan_state_e          state_q, state_d;
    logic [REG_AW-1:0]    addr_q, addr_d;
    logic [INTV_W-1:0]    intv_q, intv_d;
    logic [TO_W-1:0]      tmo_q, tmo_d;
    rd_rsp_t              rsp_q, rsp_d;
    logic                 rd_req_q, rd_req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 crc_err_q, crc_err_d;
    logic                 to_err_q, to_err_d;
    logic [REG_AW-1:0]    err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] crc_cnt_q, crc_cnt_d;
    logic [ERR_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [REG_CRC_W-1:0] crc_calc_c;

    hv_reg_crc_calc #(
        .AW    (REG_AW),
        .DW    (REG_DW),
        .CRC_W (REG_CRC_W),
        .POLY  (CRC_POLY),
        .INIT  (CRC_INIT)
    ) u_crc (
        .addr  (addr_q),
        .data  (rsp_q.data),
        .crc_c (crc_calc_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        intv_d     = intv_q;
        tmo_d      = tmo_q;
        rsp_d      = rsp_q;
        done_d     = 1'b0;
        crc_err_d  = 1'b0;
        to_err_d   = 1'b0;
        err_addr_d = err_addr_q;
        crc_cnt_d  = crc_cnt_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_scan_en) begin
                    intv_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_scan_en) begin
                    state_d = ST_IDLE;
                end else if (intv_q == INTV_LAST) begin
                    addr_d  = START_A;
                    tmo_d   = '0;
                    state_d = ST_REQ;
                end else begin
                    intv_d = intv_q + 1'b1;
                end
            end
            ST_REQ: begin
                // Ack wins over a timeout expiring in the same cycle
                if (rac.ack) begin
                    rsp_d   = rac.rsp;
                    state_d = ST_CHK;
                end else if (tmo_q == TO_LAST) begin
                    to_err_d   = 1'b1;
                    err_addr_d = addr_q;
                    to_cnt_d   = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
                    state_d    = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHK: begin
                if (crc_calc_c != rsp_q.crc) begin
                    crc_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    crc_cnt_d  = (crc_cnt_q == '1) ? crc_cnt_q : crc_cnt_q + 1'b1;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (addr_q == END_A) begin
                    done_d  = 1'b1;
                    intv_d  = '0;
                    state_d = i_scan_en ? ST_WAIT : ST_IDLE;
                end else begin
                    // Disabling mid-sweep abandons the rest of the window
                    addr_d  = addr_q + 1'b1;
                    tmo_d   = '0;
                    state_d = i_scan_en ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_req_d = (state_d == ST_REQ);
        busy_d   = (state_d == ST_REQ) || (state_d == ST_CHK) || (state_d == ST_NEXT);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= START_A;
            intv_q     <= '0;
            tmo_q      <= '0;
            rsp_q      <= '0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            to_err_q   <= 1'b0;
            err_addr_q <= '0;
            crc_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            intv_q     <= intv_d;
            tmo_q      <= tmo_d;
            rsp_q      <= rsp_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            to_err_q   <= to_err_d;
            err_addr_q <= err_addr_d;
            crc_cnt_q  <= crc_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign rac.rd_req    = rd_req_q;
    assign rac.addr      = addr_q;
    assign o_scan_busy   = busy_q;
    assign o_scan_done   = done_q;
    assign o_crc_err     = crc_err_q;
    assign o_to_err      = to_err_q;
    assign o_err_addr    = err_addr_q;
    assign o_crc_err_cnt = crc_cnt_q;
    assign o_to_err_cnt  = to_cnt_q;

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Directed bench for hv_wdg_reg_scan: window 0..3, short sweep interval, 2-bit error counters.
module tb_hv_wdg_reg_scan;
    import hv_wdg_reg_scan_pkg::*;

    localparam int unsigned END_A  = 3;
    localparam int unsigned INTV   = 4;
    localparam int unsigned ACK_TO = 64;
    localparam int unsigned CW     = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic scan_en;
    logic busy, done, crc_err, to_err;
    logic [REG_AW-1:0] err_addr;
    logic [CW-1:0]     crc_cnt, to_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int done_ev  = 0;
    int crc_ev   = 0;
    int to_ev    = 0;
    int req_rise = 0;
    logic req_prev = 1'b0;
    logic [CW-1:0] exp_crc_cnt = '0;
    logic [CW-1:0] exp_to_cnt  = '0;

    hv_wdg_reg_scan_if rac();

    hv_wdg_reg_scan #(
        .SCAN_START_ADDR (0),
        .SCAN_END_ADDR   (END_A),
        .SCAN_INTV_CYC   (INTV),
        .ACK_TO_CYC      (ACK_TO),
        .ERR_CNT_W       (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scan_en     (scan_en),
        .rac           (rac),
        .o_scan_busy   (busy),
        .o_scan_done   (done),
        .o_crc_err     (crc_err),
        .o_to_err      (to_err),
        .o_err_addr    (err_addr),
        .o_crc_err_cnt (crc_cnt),
        .o_to_err_cnt  (to_cnt)
    );

    always #5 clk = ~clk;

    // Event counters sampled on the inactive edge
    always @(negedge clk) begin
        if (done)    done_ev++;
        if (crc_err) crc_ev++;
        if (to_err)  to_ev++;
        if (rac.rd_req && !req_prev) req_rise++;
        req_prev = rac.rd_req;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    function automatic logic [REG_DW-1:0] data_for(input logic [REG_AW-1:0] a);
        return REG_DW'(8'hA5 + 8'(a) * 8'd37);
    endfunction

    // Reference CRC as polynomial remainder: ({msg,0^8} ^ init<<15) mod x^8+x^2+x+1
    function automatic logic [7:0] model_crc(input logic [6:0] a, input logic [7:0] d);
        logic [22:0] w;
        w = {a, d, 8'h00} ^ {8'hFF, 15'h0000};
        for (int i = 22; i >= 8; i--) begin
            if (w[i]) w[i -: 9] = w[i -: 9] ^ 9'h107;
        end
        return w[7:0];
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rac.rd_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Wait for a request, ack after dly cycles, record crc_err on the three following samples
    task automatic serve(input int dly, input bit corrupt, output logic [REG_AW-1:0] a,
                         output logic [2:0] e, output bit ok);
        logic [REG_DW-1:0] d;
        wait_req(ok);
        a = rac.addr;
        e = 3'b111;
        if (ok) begin
            repeat (dly) @(negedge clk);
            d = data_for(a);
            rac.rsp.data = d;
            rac.rsp.crc  = model_crc(a, d) ^ REG_CRC_W'(corrupt);
            rac.ack      = 1'b1;
            @(negedge clk);
            rac.ack = 1'b0;
            rac.rsp = rd_rsp_t'(16'($urandom));
            e[0] = crc_err;
            @(negedge clk);
            e[1] = crc_err;
            @(negedge clk);
            e[2] = crc_err;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; scan_en = 1'b0; rac.ack = 1'b0; rac.rsp = '0;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({rac.rd_req, rac.addr, busy, done, crc_err, to_err, err_addr, crc_cnt, to_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%0h busy=%b done=%b ce=%b te=%b ea=%0h cc=%0d tc=%0d expected all 0",
                     rac.rd_req, rac.addr, busy, done, crc_err, to_err, err_addr, crc_cnt, to_cnt);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_assert++;
        if (rac.rd_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_idle: req=%b busy=%b expected 0 0", rac.rd_req, busy);
        end
    endtask

    task automatic test_clean_sweep();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        int d0, r0, c0, t0;
        d0 = done_ev; r0 = req_rise; c0 = crc_ev; t0 = to_ev;
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(3, 1'b0, a, e, ok);
            n_assert++;
            if (!ok || a !== REG_AW'(i) || e !== 3'b000) begin
                n_fail++;
                $display("FAIL clean_req[%0d]: ok=%b addr=%0h crc_err=%b expected addr %0h crc_err 000", i, ok, a, e, i);
            end
        end
        repeat (2) @(negedge clk);
        n_assert++;
        if (done_ev - d0 !== 1 || req_rise - r0 !== 4 || crc_ev - c0 !== 0 || to_ev - t0 !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_summary: done=%0d reqs=%0d crc=%0d to=%0d busy=%b expected 1 4 0 0 0",
                     done_ev - d0, req_rise - r0, crc_ev - c0, to_ev - t0, busy);
        end
    endtask

    task automatic test_crc_err();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        int c0;
        c0 = crc_ev;
        // Stray ack while waiting between sweeps must be ignored
        rac.rsp = '0; rac.ack = 1'b1;
        @(negedge clk);
        rac.ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve(2, i == 2, a, e, ok);
            n_assert++;
            if (!ok || a !== REG_AW'(i) || e !== ((i == 2) ? 3'b010 : 3'b000)) begin
                n_fail++;
                $display("FAIL crc_req[%0d]: ok=%b addr=%0h crc_err=%b expected addr %0h crc_err %b",
                         i, ok, a, e, i, (i == 2) ? 3'b010 : 3'b000);
            end
            if (i == 2) begin
                exp_crc_cnt = exp_crc_cnt + 1'b1;
                n_assert++;
                if (err_addr !== 7'd2 || crc_cnt !== exp_crc_cnt) begin
                    n_fail++;
                    $display("FAIL crc_err_status: err_addr=%0h cnt=%0d expected 2 %0d", err_addr, crc_cnt, exp_crc_cnt);
                end
            end
        end
        n_assert++;
        if (crc_ev - c0 !== 1) begin
            n_fail++;
            $display("FAIL crc_err_total: pulses=%0d expected 1", crc_ev - c0);
        end
    endtask

    task automatic test_timeout();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        int hi;
        serve(1, 1'b0, a, e, ok);
        n_assert++;
        if (!ok || a !== 7'd0) begin
            n_fail++;
            $display("FAIL to_first_req: ok=%b addr=%0h expected 0", ok, a);
        end
        wait_req(ok);
        hi = 0;
        while (rac.rd_req && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        n_assert++;
        if (!ok || hi !== 64) begin
            n_fail++;
            $display("FAIL to_req_width: ok=%b cycles=%0d expected 64", ok, hi);
        end
        exp_to_cnt = exp_to_cnt + 1'b1;
        n_assert++;
        if (to_err !== 1'b1 || err_addr !== 7'd1 || to_cnt !== exp_to_cnt) begin
            n_fail++;
            $display("FAIL to_status: to_err=%b err_addr=%0h cnt=%0d expected 1 1 %0d", to_err, err_addr, to_cnt, exp_to_cnt);
        end
        for (int i = 2; i < 4; i++) begin
            serve(1, 1'b0, a, e, ok);
            n_assert++;
            if (!ok || a !== REG_AW'(i) || e !== 3'b000) begin
                n_fail++;
                $display("FAIL to_after_req[%0d]: ok=%b addr=%0h crc_err=%b expected addr %0h", i, ok, a, e, i);
            end
        end
    endtask

    task automatic test_ack_at_timeout();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        logic [REG_DW-1:0] d;
        int t0, c0;
        t0 = to_ev; c0 = crc_ev;
        wait_req(ok);
        a = rac.addr;
        repeat (ACK_TO - 1) @(negedge clk);
        n_assert++;
        if (!ok || a !== 7'd0 || rac.rd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL late_ack_req: ok=%b addr=%0h req=%b expected addr 0 req 1", ok, a, rac.rd_req);
        end
        d = data_for(a);
        rac.rsp.data = d; rac.rsp.crc = model_crc(a, d); rac.ack = 1'b1;
        @(negedge clk);
        rac.ack = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (to_ev - t0 !== 0 || crc_ev - c0 !== 0 || to_cnt !== exp_to_cnt) begin
            n_fail++;
            $display("FAIL late_ack_no_timeout: to_pulses=%0d crc_pulses=%0d to_cnt=%0d expected 0 0 %0d",
                     to_ev - t0, crc_ev - c0, to_cnt, exp_to_cnt);
        end
        for (int i = 1; i < 4; i++) begin
            serve(0, 1'b0, a, e, ok);
            n_assert++;
            if (!ok || a !== REG_AW'(i) || e !== 3'b000) begin
                n_fail++;
                $display("FAIL late_ack_next[%0d]: ok=%b addr=%0h crc_err=%b expected addr %0h", i, ok, a, e, i);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        logic [REG_DW-1:0] d;
        int lows, r1, d1;
        serve(2, 1'b0, a, e, ok);
        wait_req(ok);
        a = rac.addr;
        n_assert++;
        if (!ok || a !== 7'd1) begin
            n_fail++;
            $display("FAIL drop_req_addr: ok=%b addr=%0h expected 1", ok, a);
        end
        scan_en = 1'b0;
        lows = 0;
        repeat (5) begin
            @(negedge clk);
            if (rac.rd_req !== 1'b1) lows++;
        end
        n_assert++;
        if (lows !== 0) begin
            n_fail++;
            $display("FAIL drop_req_held: low_cycles=%0d expected 0", lows);
        end
        r1 = req_rise; d1 = done_ev;
        d = data_for(a);
        rac.rsp.data = d; rac.rsp.crc = model_crc(a, d) ^ 8'h01; rac.ack = 1'b1;
        @(negedge clk);
        rac.ack = 1'b0;
        @(negedge clk);
        exp_crc_cnt = (exp_crc_cnt == '1) ? exp_crc_cnt : exp_crc_cnt + 1'b1;
        n_assert++;
        if (crc_err !== 1'b1 || err_addr !== 7'd1 || crc_cnt !== exp_crc_cnt) begin
            n_fail++;
            $display("FAIL drop_checked: crc_err=%b err_addr=%0h cnt=%0d expected 1 1 %0d", crc_err, err_addr, crc_cnt, exp_crc_cnt);
        end
        repeat (2) @(negedge clk);
        n_assert++;
        if (rac.rd_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: req=%b busy=%b expected 0 0", rac.rd_req, busy);
        end
        repeat (20) @(negedge clk);
        n_assert++;
        if (req_rise !== r1 || done_ev !== d1) begin
            n_fail++;
            $display("FAIL drop_no_more: new_reqs=%0d done=%0d expected 0 0", req_rise - r1, done_ev - d1);
        end
    endtask

    task automatic test_saturation();
        logic [REG_AW-1:0] a; logic [2:0] e; bit ok;
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(1, 1'b1, a, e, ok);
            exp_crc_cnt = (exp_crc_cnt == '1) ? exp_crc_cnt : exp_crc_cnt + 1'b1;
            n_assert++;
            if (!ok || a !== REG_AW'(i) || e !== 3'b010 || crc_cnt !== exp_crc_cnt) begin
                n_fail++;
                $display("FAIL sat[%0d]: ok=%b addr=%0h crc_err=%b cnt=%0d expected addr %0h 010 cnt %0d",
                         i, ok, a, e, crc_cnt, i, exp_crc_cnt);
            end
        end
        n_assert++;
        if (crc_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_final: cnt=%0d expected 3", crc_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_req(ok);
        n_assert++;
        if (!ok || rac.rd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: ok=%b req=%b expected 1", ok, rac.rd_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++;
        if (rac.rd_req !== 1'b0 || busy !== 1'b0 || crc_cnt !== '0 || to_cnt !== '0 || err_addr !== '0) begin
            n_fail++;
            $display("FAIL areset_now: req=%b busy=%b cc=%0d tc=%0d ea=%0h expected all 0",
                     rac.rd_req, busy, crc_cnt, to_cnt, err_addr);
        end
        @(negedge clk);
        scan_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_crc_err();
        test_timeout();
        test_ack_at_timeout();
        test_en_drop();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
